fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset; synchronous and active-low.
REQ-005 Port imem_req, output, 1: instruction-memory read request, valid for one cycle.
REQ-006 Port imem_addr, output, 32: word-aligned fetch address, valid with imem_req.
REQ-007 Port imem_rvalid, input, 1: read data valid; responses return in order, at least 1 cycle after the request.
REQ-008 Port imem_rdata, input, 32: instruction word, valid with imem_rvalid.
REQ-009 Port isHazard, input, 1: decode stall; holds the current output.
REQ-010 Port redirect_valid, input, 1: branch/jump redirect strobe.
REQ-011 Port redirect_pc, input, 32: redirect target.
REQ-012 Port reg_instruction, output, 32: instruction presented to decode.
REQ-013 Port reg_pc, output, 32: PC of reg_instruction.
REQ-014 Port reg_valid, output, 1: reg_instruction is a real fetched instruction.

Function
REQ-015 imem_req SHALL assert when no redirect is pending and (queue count + outstanding) < DEPTH; imem_addr SHALL equal pc; pc SHALL advance by 4 on each issued request.
REQ-016 Outstanding count: +1 per issued request, -1 per imem_rvalid; a request and a response in the same cycle SHALL leave it unchanged.
REQ-017 A non-discarded imem_rvalid SHALL push {imem_rdata, its request address} into the queue at that edge; the entry SHALL be visible on the outputs from the next cycle (1-cycle response-to-decode latency).
REQ-018 Outputs SHALL present the queue head; when the queue is empty, reg_valid=0, reg_instruction=NOP (32'h0000_0000), and reg_pc holds its last value.
REQ-019 The head SHALL pop when reg_valid=1 and isHazard=0; with isHazard=1 the outputs SHALL hold unchanged.
REQ-020 A push and a pop in the same cycle SHALL both take effect; the count is unchanged.
REQ-021 Push while full SHALL never occur; this is guaranteed by REQ-015 and is covered by an assertion.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 On redirect_valid=1, at the next edge:
- pc <= {redirect_pc[31:2],2'b00}
- the queue is flushed
- discard_cnt <= outstanding after this cycle's update
- imem_req SHALL be 0 in the redirect cycle
REQ-024 Responses arriving while discard_cnt>0 SHALL be dropped, and each SHALL decrement discard_cnt; fetching resumes on the cycle after the redirect.
REQ-025 Redirect SHALL take priority over isHazard; a same-cycle pop and redirect SHALL result in an empty queue.
REQ-026 Back-to-back redirects: the last one wins; discard accounting SHALL remain exact.

Reset
REQ-027 While rst=0 at an edge, the block SHALL set: pc=RESET_PC, queue empty, outstanding=0, discard_cnt=0, imem_req=0, imem_addr=RESET_PC, reg_valid=0, reg_instruction=NOP, reg_pc=RESET_PC.
REQ-028 Responses arriving during reset or after reset release for pre-reset requests are not supported; the memory SHALL be reset together with this block.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN: when defined, output stall_cycles (32) SHALL count cycles with reg_valid=1 and isHazard=1, and output empty_cycles (32) SHALL count cycles with reg_valid=0. Both counters reset to 0, saturate at all-ones, and are not cleared by redirect. When the macro is undefined, neither port nor its logic SHALL exist.

Structure
REQ-030 Shared package mips_pkg SHALL hold: INSTR_W=32, NOP constant, default RESET_PC, and the fetch-entry struct {instr, pc}.
REQ-031 Queue storage SHALL be the sub-module fetch_fifo (DEPTH-parameterised; push/pop/flush/count).

Verification
REQ-032 Reset, then rst=1 with memory latency 1 -> imem_addr 0,4,8,… on consecutive cycles; reg_valid first rises 2 cycles after the first request, with reg_pc=0.
REQ-033 isHazard=1 held for 5 cycles -> outputs frozen; imem_req stops once count+outstanding=4; no data lost after release.
REQ-034 Memory latency 3, redirect to 32'h0000_0103 with 2 requests outstanding -> both responses dropped; next imem_addr=32'h0000_0100; first reg_valid shows reg_pc=32'h100.
REQ-035 Redirect asserted together with isHazard=1 and a full queue -> queue empty next cycle; reg_valid=0; reg_instruction=32'h0.
REQ-036 Random latency 1..4 with random isHazard over 10,000 cycles -> reg_pc sequence strictly +4 between redirects; no overflow assertion fires.
REQ-037 With FETCH_PERF_CNT_EN defined: 7 hazard cycles and 3 empty cycles -> stall_cycles=7, empty_cycles=3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants: instruction width, NOP encoding,
// default reset PC and the {instr, pc} queue entry.
package mips_pkg;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction queue with push/pop/flush; head visible the cycle after push.
// No internal backpressure: the caller keeps occupancy below DEPTH before pushing.
module fetch_fifo import mips_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           push_dat_i,
  output fetch_entry_t           head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign count_d = count_q + (AW+1)'(push_i) - (AW+1)'(do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push_i && count_q == FULL_C));
endmodule

// File: rtl/fetch_queue.sv
// Fetch unit: issues in-order imem reads, queues responses, presents head to decode 1 cycle after response.
// Stalls requests when queue+outstanding reaches DEPTH; isHazard holds output. Option: FETCH_PERF_CNT_EN.
module fetch_queue import mips_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        isHazard,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] reg_instruction,
  output logic [31:0] reg_pc,
  output logic        reg_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] empty_cycles
`endif
);
  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d, last_pc_q, target_pc;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, fifo_cnt;
  logic [CW:0]   occ;
  logic          push, pop, drop;
  fetch_entry_t  head, push_ent;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign target_pc      = {redirect_pc[31:2], 2'b00};

  assign occ       = {1'b0, fifo_cnt} + {1'b0, out_q};
  assign imem_req  = rst && !redirect_valid && (occ < DEPTH_C);
  assign imem_addr = pc_q;

  assign drop     = imem_rvalid && (disc_q != '0);
  assign push     = imem_rvalid && !drop && !redirect_valid;
  assign reg_valid = (fifo_cnt != '0);
  assign pop      = reg_valid && !isHazard && !redirect_valid;
  assign push_ent = '{instr: imem_rdata, pc: resp_pc_q};

  // resp_pc tracks the address of the next kept response; responses are in order.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    disc_d    = disc_q;
    out_d     = out_q + CW'(imem_req) - CW'(imem_rvalid);
    if (redirect_valid) begin
      pc_d      = target_pc;
      resp_pc_d = target_pc;
      disc_d    = out_d;
    end else begin
      if (imem_req) pc_d      = pc_q + 32'd4;
      if (drop)     disc_d    = disc_q - CW'(1);
      if (push)     resp_pc_d = resp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      last_pc_q <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
      if (reg_valid) last_pc_q <= head.pc;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_n_i    (rst),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .push_dat_i (push_ent),
    .head_dat_o (head),
    .count_o    (fifo_cnt)
  );

  assign reg_instruction = reg_valid ? head.instr : NOP;
  assign reg_pc          = reg_valid ? head.pc : last_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, empty_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      empty_q <= '0;
    end else begin
      if (reg_valid && isHazard && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (!reg_valid && empty_q != '1)            empty_q <= empty_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign empty_cycles = empty_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written redirect/hazard sequences,
// and random latency/hazard/redirect traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk, rst, imem_req, imem_rvalid, isHazard, redirect_valid, reg_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, reg_instruction, reg_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, empty_cycles;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .isHazard        (isHazard),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .reg_instruction (reg_instruction),
    .reg_pc          (reg_pc),
    .reg_valid       (reg_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .empty_cycles    (empty_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;
  typedef struct {
    logic rv; logic [31:0] rd; logic hz; logic redir; logic [31:0] rpc;
    logic req; logic [31:0] addr; logic v; logic [31:0] ins; logic [31:0] pc;
  } vec_t;

  int n_chk = 0, n_fail = 0, cyc = 0, lat_mode = 1, last_due = -1;
  ent_t        mq[$];
  logic [31:0] maddr[$];
  mreq_t       sched[$];
  logic [31:0] m_pc, m_shown;
  int          m_disc, m_stall, m_empty;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    isHazard = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", reg_valid, 0);
    chk("rst_instr", reg_instruction, 32'h0);
    chk("rst_pc", reg_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cycles, 0);
    chk("rst_empty_cnt", empty_cycles, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    mq.delete(); maddr.delete(); sched.delete();
    m_pc = 32'h0; m_shown = 32'h0; m_disc = 0; m_stall = 0; m_empty = 0;
    last_due = -1; cyc = 0;
  endtask

  // One cycle of memory + model; called just after a rising edge.
  task automatic env_cycle(input logic hz, input logic rd, input logic [31:0] rpc);
    mreq_t r; ent_t e; logic [31:0] a, rdat; logic rv, e_req, e_valid;
    logic [31:0] e_instr, e_pc; int due;
    rv = 1'b0; rdat = '0;
    if (sched.size() > 0 && sched[0].due == cyc) begin
      r = sched.pop_front();
      rv = 1'b1;
      rdat = mem_word(r.addr);
    end
    isHazard = hz; redirect_valid = rd; redirect_pc = rpc;
    imem_rvalid = rv; imem_rdata = rdat;
    @(negedge clk);
    e_req   = !rd && (mq.size() + maddr.size() < DEPTH);
    e_valid = mq.size() > 0;
    e_instr = e_valid ? mq[0].instr : 32'h0;
    e_pc    = e_valid ? mq[0].pc : m_shown;
    s_req = imem_req; s_addr = imem_addr; s_valid = reg_valid;
    s_instr = reg_instruction; s_pc = reg_pc;
    chk("imem_req", s_req, e_req);
    chk("imem_addr", s_addr, m_pc);
    chk("reg_valid", s_valid, e_valid);
    chk("reg_instruction", s_instr, e_instr);
    chk("reg_pc", s_pc, e_pc);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("empty_cycles", empty_cycles, m_empty);
    if (e_valid && hz) m_stall++;
    if (!e_valid) m_empty++;
`endif
    if (imem_req === 1'b1) begin
      due = cyc + ((lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      sched.push_back('{due, imem_addr});
    end
    m_shown = e_pc;
    if (rd) begin
      if (rv && maddr.size() > 0) a = maddr.pop_front();
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
      m_disc = maddr.size();
    end else begin
      if (e_valid && !hz) e = mq.pop_front();
      if (rv && maddr.size() > 0) begin
        a = maddr.pop_front();
        if (m_disc > 0) m_disc--;
        else mq.push_back('{mem_word(a), a});
      end
      if (e_req) begin
        maddr.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t        tbl[15];
  logic [31:0] frz_pc, frz_instr;
  logic        found;

  initial begin
    // rv, rdata, hz, redir, rpc | req, addr, valid, instr, pc
    tbl[0]  = '{0, 32'h0,         0, 0, 32'h0,   1, 32'h00,  0, 32'h0,         32'h00};
    tbl[1]  = '{1, 32'hA000_0001, 0, 0, 32'h0,   1, 32'h04,  0, 32'h0,         32'h00};
    tbl[2]  = '{1, 32'hA000_0002, 0, 0, 32'h0,   1, 32'h08,  1, 32'hA000_0001, 32'h00};
    tbl[3]  = '{1, 32'hA000_0003, 1, 0, 32'h0,   1, 32'h0C,  1, 32'hA000_0002, 32'h04};
    tbl[4]  = '{1, 32'hA000_0004, 1, 0, 32'h0,   1, 32'h10,  1, 32'hA000_0002, 32'h04};
    tbl[5]  = '{1, 32'hA000_0005, 1, 0, 32'h0,   0, 32'h14,  1, 32'hA000_0002, 32'h04};
    tbl[6]  = '{0, 32'h0,         1, 0, 32'h0,   0, 32'h14,  1, 32'hA000_0002, 32'h04};
    tbl[7]  = '{0, 32'h0,         0, 0, 32'h0,   0, 32'h14,  1, 32'hA000_0002, 32'h04};
    tbl[8]  = '{0, 32'h0,         0, 0, 32'h0,   1, 32'h14,  1, 32'hA000_0003, 32'h08};
    tbl[9]  = '{1, 32'hA000_0006, 0, 0, 32'h0,   1, 32'h18,  1, 32'hA000_0004, 32'h0C};
    tbl[10] = '{0, 32'h0,         1, 1, 32'h103, 0, 32'h1C,  1, 32'hA000_0005, 32'h10};
    tbl[11] = '{1, 32'hA000_0007, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,         32'h10};
    tbl[12] = '{1, 32'hA000_0008, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0,         32'h10};
    tbl[13] = '{0, 32'h0,         0, 0, 32'h0,   1, 32'h108, 1, 32'hA000_0008, 32'h100};
    tbl[14] = '{0, 32'h0,         0, 0, 32'h0,   1, 32'h10C, 0, 32'h0,         32'h100};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd; isHazard = tbl[i].hz;
      redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), imem_req, tbl[i].req);
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), reg_valid, tbl[i].v);
      chk($sformatf("vec%0d_instr", i), reg_instruction, tbl[i].ins);
      chk($sformatf("vec%0d_pc", i), reg_pc, tbl[i].pc);
      @(posedge clk); #1;
      cyc++;
    end

    // Latency-3 redirect with two requests in flight.
    do_reset();
    lat_mode = 3;
    env_cycle(0, 0, 0);
    env_cycle(0, 0, 0);
    env_cycle(0, 1, 32'h0000_0103);
    chk("redir_cycle_req", s_req, 0);
    env_cycle(0, 0, 0);
    chk("post_redir_req", s_req, 1);
    chk("post_redir_addr", s_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      env_cycle(0, 0, 0);
      if (s_valid) begin
        found = 1'b1;
        chk("redir_first_pc", s_pc, 32'h100);
      end
    end
    chk("redir_first_seen", found, 1);

    // Hazard fills the queue, then redirect under hazard flushes it.
    do_reset();
    lat_mode = 1;
    env_cycle(0, 0, 0);
    env_cycle(0, 0, 0);
    env_cycle(1, 0, 0);
    frz_pc = s_pc; frz_instr = s_instr;
    for (int i = 0; i < 5; i++) begin
      env_cycle(1, 0, 0);
      chk("hz_frozen_pc", s_pc, frz_pc);
      chk("hz_frozen_instr", s_instr, frz_instr);
    end
    chk("hz_full_req", s_req, 0);
    env_cycle(1, 1, 32'h0000_0400);
    chk("full_redir_valid", s_valid, 1);
    env_cycle(0, 0, 0);
    chk("flush_valid", s_valid, 0);
    chk("flush_instr", s_instr, 32'h0);
    for (int i = 0; i < 4; i++) env_cycle(0, 0, 0);
    for (int i = 0; i < 5; i++) env_cycle(1, 0, 0);
    for (int i = 0; i < 12; i++) env_cycle(0, 0, 0);

    // Back-to-back redirects: only the last target survives.
    do_reset();
    lat_mode = 3;
    for (int i = 0; i < 3; i++) env_cycle(0, 0, 0);
    env_cycle(0, 1, 32'h0000_0200);
    env_cycle(0, 1, 32'h0000_0301);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      env_cycle(0, 0, 0);
      if (s_valid) begin
        found = 1'b1;
        chk("b2b_first_pc", s_pc, 32'h300);
      end
    end
    chk("b2b_first_seen", found, 1);

    // Random latency, hazards and redirects.
    do_reset();
    lat_mode = 0;
    for (int i = 0; i < 10000; i++) begin
      logic        hz, rd;
      logic [31:0] rp;
      hz = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 3);
      rp = $urandom_range(0, 32'h0000_FFFF);
      env_cycle(hz, rd, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
